data_bus_mux: RTL and testbench



---
 rtl/cgra_pkg.sv | 24 ++
 rtl/data_bus_mux_resp_fifo.sv | 74 +++++++
 rtl/data_bus_mux.sv | 178 +++++++++++++++++
 tb/tb_data_bus_mux.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA parameters and types used by the data bus mux.
package cgra_pkg;

    localparam int N_COL               = 4;
    localparam int N_COL_LOG2          = $clog2(N_COL);
    localparam int DATA_BUS_ADD_WIDTH  = 32;
    localparam int DATA_BUS_DATA_WIDTH = 32;
    localparam int DATA_BUS_MUX_DEPTH  = 4;

    typedef struct packed {
        logic [N_COL_LOG2-1:0] col_id;
        logic                  is_read;
    } data_bus_mux_entry_t;

    // Round-robin successor of a column index.
    function automatic logic [N_COL_LOG2-1:0] next_col(input logic [N_COL_LOG2-1:0] idx);
        if (idx == N_COL_LOG2'(N_COL - 1)) begin
            return '0;
        end else begin
            return idx + N_COL_LOG2'(1);
        end
    endfunction

endpackage

// File: rtl/data_bus_mux_resp_fifo.sv
// In-order queue of outstanding data bus transactions ({col_id, is_read}).
module data_bus_mux_resp_fifo
    import cgra_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  data_bus_mux_entry_t entry_i,
    input  logic                pop_i,
    output logic                full_o,
    output logic                empty_o,
    output data_bus_mux_entry_t head_o
);

    localparam int AW = $clog2(DEPTH);

    data_bus_mux_entry_t mem_q [DEPTH];
    data_bus_mux_entry_t mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = entry_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/data_bus_mux.sv
// Merges N_COL column data bus masters onto one system master port.
// Define DATA_BUS_MUX_RR_EN for round-robin arbitration; default is fixed priority.
module data_bus_mux #(
    parameter int N_COL       = cgra_pkg::N_COL,
    parameter int OUTST_DEPTH = cgra_pkg::DATA_BUS_MUX_DEPTH
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    input  logic [N_COL-1:0]                                   col_req_i,
    input  logic [N_COL-1:0][cgra_pkg::DATA_BUS_ADD_WIDTH-1:0]  col_add_i,
    input  logic [N_COL-1:0]                                   col_wen_i,
    input  logic [N_COL-1:0][3:0]                              col_be_i,
    input  logic [N_COL-1:0][cgra_pkg::DATA_BUS_DATA_WIDTH-1:0] col_wdata_i,
    output logic [N_COL-1:0]                                   col_gnt_o,
    output logic [N_COL-1:0][cgra_pkg::DATA_BUS_DATA_WIDTH-1:0] col_rdata_o,
    output logic [N_COL-1:0]                                   col_rvalid_o,
    output logic                                               mst_req_o,
    output logic [cgra_pkg::DATA_BUS_ADD_WIDTH-1:0]             mst_add_o,
    output logic                                               mst_wen_o,
    output logic [3:0]                                         mst_be_o,
    output logic [cgra_pkg::DATA_BUS_DATA_WIDTH-1:0]            mst_wdata_o,
    input  logic                                               mst_gnt_i,
    input  logic [cgra_pkg::DATA_BUS_DATA_WIDTH-1:0]            mst_rdata_i,
    input  logic                                               mst_rvalid_i,
    output logic                                               err_o
);

    import cgra_pkg::*;

    localparam int COL_W = N_COL_LOG2;

    logic                any_req;
    logic                full;
    logic                empty;
    logic                grant;
    logic                use_lock;
    logic                lock_drop;
    logic                found;
    int                  cand;
    logic [COL_W-1:0]    win;
    data_bus_mux_entry_t push_entry;
    data_bus_mux_entry_t head;

    logic                locked_q, locked_d;
    logic [COL_W-1:0]    lock_idx_q, lock_idx_d;
    logic                err_q, err_d;
`ifdef DATA_BUS_MUX_RR_EN
    logic [COL_W-1:0]    rr_q, rr_d;
`endif

    assign any_req   = |col_req_i;
    assign lock_drop = locked_q & ~col_req_i[lock_idx_q];
    assign use_lock  = locked_q & col_req_i[lock_idx_q];
    assign mst_req_o = any_req & ~full;
    assign grant     = mst_req_o & mst_gnt_i;
    assign err_o     = err_q;

    // Winner selection: held lock, else first requester from the search start.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = 0;
        if (use_lock) begin
            win = lock_idx_q;
        end else begin
            for (int i = 0; i < N_COL; i++) begin
`ifdef DATA_BUS_MUX_RR_EN
                cand = (int'(rr_q) + i) % N_COL;
`else
                cand = i;
`endif
                if (!found && col_req_i[cand]) begin
                    found = 1'b1;
                    win   = COL_W'(cand);
                end else begin
                    found = found;
                end
            end
        end
    end

    // Master request fields and column grant.
    always_comb begin
        col_gnt_o = '0;
        if (any_req) begin
            mst_add_o   = col_add_i[win];
            mst_wen_o   = col_wen_i[win];
            mst_be_o    = col_be_i[win];
            mst_wdata_o = col_wdata_i[win];
        end else begin
            mst_add_o   = '0;
            mst_wen_o   = 1'b0;
            mst_be_o    = 4'h0;
            mst_wdata_o = '0;
        end
        if (grant) begin
            col_gnt_o[win] = 1'b1;
        end else begin
            col_gnt_o = '0;
        end
    end

    // Response routing: data broadcast, valid only to the reading column at the head.
    always_comb begin
        col_rvalid_o = '0;
        for (int k = 0; k < N_COL; k++) begin
            col_rdata_o[k] = mst_rdata_i;
        end
        if (mst_rvalid_i && !empty && head.is_read) begin
            col_rvalid_o[head.col_id] = 1'b1;
        end else begin
            col_rvalid_o = '0;
        end
    end

    // Lock, error and arbitration pointer next-state.
    always_comb begin
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q;
        if (lock_drop || (mst_rvalid_i && empty)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (mst_req_o && !mst_gnt_i) begin
            locked_d   = 1'b1;
            lock_idx_d = win;
        end else if (grant || lock_drop) begin
            locked_d = 1'b0;
        end else begin
            locked_d = locked_q;
        end
`ifdef DATA_BUS_MUX_RR_EN
        if (grant) begin
            rr_d = next_col(win);
        end else begin
            rr_d = rr_q;
        end
`endif
    end

    // Control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
`ifdef DATA_BUS_MUX_RR_EN
            rr_q       <= '0;
`endif
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
`ifdef DATA_BUS_MUX_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign push_entry.col_id  = win;
    assign push_entry.is_read = col_wen_i[win];

    data_bus_mux_resp_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .entry_i (push_entry),
        .pop_i   (mst_rvalid_i),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_data_bus_mux.sv
// Directed self-checking bench for data_bus_mux (either arbitration build).
module tb_data_bus_mux;

    import cgra_pkg::*;

    logic                                       clk_i;
    logic                                       rst_i;
    logic [N_COL-1:0]                           col_req_i;
    logic [N_COL-1:0][DATA_BUS_ADD_WIDTH-1:0]   col_add_i;
    logic [N_COL-1:0]                           col_wen_i;
    logic [N_COL-1:0][3:0]                      col_be_i;
    logic [N_COL-1:0][DATA_BUS_DATA_WIDTH-1:0]  col_wdata_i;
    logic [N_COL-1:0]                           col_gnt_o;
    logic [N_COL-1:0][DATA_BUS_DATA_WIDTH-1:0]  col_rdata_o;
    logic [N_COL-1:0]                           col_rvalid_o;
    logic                                       mst_req_o;
    logic [DATA_BUS_ADD_WIDTH-1:0]              mst_add_o;
    logic                                       mst_wen_o;
    logic [3:0]                                 mst_be_o;
    logic [DATA_BUS_DATA_WIDTH-1:0]             mst_wdata_o;
    logic                                       mst_gnt_i;
    logic [DATA_BUS_DATA_WIDTH-1:0]             mst_rdata_i;
    logic                                       mst_rvalid_i;
    logic                                       err_o;

    int total = 0;
    int bad   = 0;

    data_bus_mux dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .col_req_i    (col_req_i),
        .col_add_i    (col_add_i),
        .col_wen_i    (col_wen_i),
        .col_be_i     (col_be_i),
        .col_wdata_i  (col_wdata_i),
        .col_gnt_o    (col_gnt_o),
        .col_rdata_o  (col_rdata_o),
        .col_rvalid_o (col_rvalid_o),
        .mst_req_o    (mst_req_o),
        .mst_add_o    (mst_add_o),
        .mst_wen_o    (mst_wen_o),
        .mst_be_o     (mst_be_o),
        .mst_wdata_o  (mst_wdata_o),
        .mst_gnt_i    (mst_gnt_i),
        .mst_rdata_i  (mst_rdata_i),
        .mst_rvalid_i (mst_rvalid_i),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        col_req_i    = 4'h0;
        col_wen_i    = 4'h0;
        mst_gnt_i    = 1'b0;
        mst_rvalid_i = 1'b0;
        mst_rdata_i  = 32'h0;
        for (int k = 0; k < N_COL; k++) begin
            col_add_i[k]   = 32'h1000 + 32'(k) * 32'h100;
            col_be_i[k]    = 4'hF;
            col_wdata_i[k] = 32'hA000 + 32'(k);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    logic [3:0] exp_g;
    logic [3:0] prev_g;

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        do_reset();
        #1;
        chk("reset_err", 32'(err_o), 32'h0);
        chk("reset_req", 32'(mst_req_o), 32'h0);
        chk("reset_gnt", 32'(col_gnt_o), 32'h0);
        chk("reset_rvalid", 32'(col_rvalid_o), 32'h0);
        chk("reset_add", mst_add_o, 32'h0);

        // Single read from column 2.
        next_cycle();
        col_req_i    = 4'b0100;
        col_add_i[2] = 32'h100;
        col_wen_i    = 4'b0100;
        mst_gnt_i    = 1'b1;
        #1;
        chk("rd_req", 32'(mst_req_o), 32'h1);
        chk("rd_add", mst_add_o, 32'h100);
        chk("rd_wen", 32'(mst_wen_o), 32'h1);
        chk("rd_gnt", 32'(col_gnt_o), 32'h4);
        next_cycle();
        col_req_i = 4'b0000;
        mst_gnt_i = 1'b0;
        #1;
        chk("rd_idle_req", 32'(mst_req_o), 32'h0);
        next_cycle();
        mst_rvalid_i = 1'b1;
        mst_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("rd_rvalid", 32'(col_rvalid_o), 32'h4);
        chk("rd_rdata2", col_rdata_o[2], 32'hDEADBEEF);
        next_cycle();
        mst_rvalid_i = 1'b0;
        #1;
        chk("rd_err", 32'(err_o), 32'h0);

        // Write from column 1: response is absorbed.
        col_req_i = 4'b0010;
        col_wen_i = 4'b0000;
        col_wdata_i[1] = 32'h55AA;
        mst_gnt_i = 1'b1;
        #1;
        chk("wr_gnt", 32'(col_gnt_o), 32'h2);
        chk("wr_wen", 32'(mst_wen_o), 32'h0);
        chk("wr_wdata", mst_wdata_o, 32'h55AA);
        next_cycle();
        col_req_i    = 4'b0000;
        mst_gnt_i    = 1'b0;
        mst_rvalid_i = 1'b1;
        #1;
        chk("wr_rvalid", 32'(col_rvalid_o), 32'h0);
        next_cycle();
        mst_rvalid_i = 1'b0;
        #1;
        chk("wr_err", 32'(err_o), 32'h0);

        // All columns reading continuously with grant held high.
        do_reset();
        prev_g = 4'h0;
        for (int c = 0; c < 5; c++) begin
            col_req_i    = 4'hF;
            col_wen_i    = 4'hF;
            mst_gnt_i    = 1'b1;
            mst_rvalid_i = (c > 0);
`ifdef DATA_BUS_MUX_RR_EN
            exp_g = 4'b0001 << (c % 4);
`else
            exp_g = 4'b0001;
`endif
            #1;
            chk("all_gnt", 32'(col_gnt_o), 32'(exp_g));
            chk("all_rvalid", 32'(col_rvalid_o), 32'(prev_g));
            prev_g = exp_g;
            next_cycle();
        end
        col_req_i    = 4'h0;
        mst_gnt_i    = 1'b0;
        mst_rvalid_i = 1'b1;
        #1;
        chk("all_last_rvalid", 32'(col_rvalid_o), 32'(prev_g));
        next_cycle();
        mst_rvalid_i = 1'b0;
        #1;
        chk("all_err", 32'(err_o), 32'h0);

        // Lock: column 3 waits 3 cycles, column 0 joins while locked.
        do_reset();
        col_add_i[3] = 32'h300;
        col_add_i[0] = 32'h0A0;
        col_wen_i    = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            col_req_i = (c == 0) ? 4'b1000 : 4'b1001;
            mst_gnt_i = 1'b0;
            #1;
            chk("lock_add", mst_add_o, 32'h300);
            chk("lock_nogrant", 32'(col_gnt_o), 32'h0);
            next_cycle();
        end
        mst_gnt_i = 1'b1;
        #1;
        chk("lock_gnt3", 32'(col_gnt_o), 32'h8);
        next_cycle();
        col_req_i = 4'b0001;
        #1;
        chk("lock_gnt0", 32'(col_gnt_o), 32'h1);
        chk("lock_add0", mst_add_o, 32'h0A0);
        next_cycle();
        col_req_i    = 4'b0000;
        mst_gnt_i    = 1'b0;
        mst_rvalid_i = 1'b1;
        #1;
        chk("lock_rsp3", 32'(col_rvalid_o), 32'h8);
        next_cycle();
        #1;
        chk("lock_rsp0", 32'(col_rvalid_o), 32'h1);
        next_cycle();
        mst_rvalid_i = 1'b0;
        #1;
        chk("lock_err", 32'(err_o), 32'h0);

        // Queue full: four grants block the fifth request.
        do_reset();
        col_req_i = 4'b0001;
        col_wen_i = 4'b0001;
        mst_gnt_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("fill_gnt", 32'(col_gnt_o), 32'h1);
            next_cycle();
        end
        #1;
        chk("full_req", 32'(mst_req_o), 32'h0);
        chk("full_gnt", 32'(col_gnt_o), 32'h0);
        next_cycle();
        mst_rvalid_i = 1'b1;
        #1;
        chk("full_pop_req", 32'(mst_req_o), 32'h0);
        chk("full_pop_rvalid", 32'(col_rvalid_o), 32'h1);
        next_cycle();
        mst_rvalid_i = 1'b0;
        #1;
        chk("unfull_req", 32'(mst_req_o), 32'h1);
        chk("unfull_gnt", 32'(col_gnt_o), 32'h1);
        next_cycle();
        col_req_i    = 4'b0000;
        mst_gnt_i    = 1'b0;
        mst_rvalid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("drain_rvalid", 32'(col_rvalid_o), 32'h1);
            next_cycle();
        end
        mst_rvalid_i = 1'b0;
        #1;
        chk("drain_err", 32'(err_o), 32'h0);

        // Illegal drop of a locked request sets the sticky error.
        do_reset();
        col_req_i = 4'b0100;
        mst_gnt_i = 1'b0;
        next_cycle();
        col_req_i = 4'b0000;
        next_cycle();
        #1;
        chk("drop_err", 32'(err_o), 32'h1);

        // Late response after a mid-operation reset, and response on empty queue.
        do_reset();
        #1;
        chk("drop_err_cleared", 32'(err_o), 32'h0);
        col_req_i = 4'b0001;
        col_wen_i = 4'b0001;
        mst_gnt_i = 1'b1;
        next_cycle();
        do_reset();
        mst_rvalid_i = 1'b1;
        #1;
        chk("late_rvalid", 32'(col_rvalid_o), 32'h0);
        next_cycle();
        mst_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("late_err_sticky", 32'(err_o), 32'h1);
            next_cycle();
        end
        do_reset();
        #1;
        chk("err_reset", 32'(err_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
